// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: imem request/response channel, EX redirect and the ID handoff.
// master = fetch stage, slave = the memory/pipeline environment around it.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_inst,
    input  imem_ack, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_inst,
    output imem_ack, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MeMIPS fetch: one outstanding imem request, rvalid->id_valid one edge later, no bypass.
// Backpressure: imem_req drops while the BUF_DEPTH-entry buffer is full; redirects flush it.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_stage_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [1:0]    state, state_nx;
  logic [31:0]   pc, pc_nx;
  logic [31:0]   req_pc, req_pc_nx;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  entry_t        ent_q [BUF_DEPTH];

  logic fire, push, pop, flush, not_empty;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  assign not_empty     = (count != '0);
  assign bus.imem_req  = (state == S_REQ) && (count < FULL_CNT);
  assign bus.imem_addr = pc;
  assign bus.id_valid  = not_empty;
  assign bus.id_pc     = not_empty ? ent_q[rd_ptr].pc   : 32'h0;
  assign bus.id_inst   = not_empty ? ent_q[rd_ptr].inst : 32'h0;

  assign fire  = bus.imem_req && bus.imem_ack;
  assign flush = bus.redirect_valid;
  assign push  = (state == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign pop   = not_empty && bus.id_ready && !bus.redirect_valid;

  // Redirect wins; an ack in the redirect cycle still leaves a response in flight to discard.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    req_pc_nx = req_pc;
    if (bus.redirect_valid) begin
      pc_nx = {bus.redirect_pc[31:2], 2'b00};
      case (state)
        S_IDLE:  state_nx = S_REQ;
        S_REQ:   state_nx = fire ? S_DROP : S_REQ;
        S_WAIT:  state_nx = bus.imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_nx = bus.imem_rvalid ? S_REQ : S_DROP;
        default: state_nx = S_REQ;
      endcase
    end else begin
      case (state)
        S_IDLE: state_nx = S_REQ;
        S_REQ: begin
          if (fire) begin
            req_pc_nx = pc;
            pc_nx     = pc + 32'd4;
            state_nx  = S_WAIT;
          end
        end
        S_WAIT:  if (bus.imem_rvalid) state_nx = S_REQ;
        S_DROP:  if (bus.imem_rvalid) state_nx = S_REQ;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= 32'h0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      req_pc <= req_pc_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) ent_q[wr_ptr] <= '{pc: req_pc, inst: bus.imem_rdata};
  end

  a_rvalid_only_when_pending: assert property (
    @(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> (state == S_WAIT || state == S_DROP)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a per-cycle vector table for start-up, backpressure
// and ack stall, then hand sequences for redirects and mid-flight reset.
module tb_if_fetch_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  if_fetch_stage_if bus();

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic a, input logic rv,
                              input logic [31:0] rd, input logic rdy, input logic c,
                              input logic q, input logic [31:0] ad, input logic v,
                              input logic [31:0] p, input logic [31:0] ins);
    vec_t t;
    t.rst = r; t.ack = a; t.rvalid = rv; t.rdata = rd; t.rdy = rdy; t.chk = c;
    t.req = q; t.addr = ad; t.vld = v; t.pc = p; t.inst = ins;
    return t;
  endfunction

  function automatic logic [31:0] iw(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = 1'b1;

    // rst ack rv rdata rdy chk | req addr vld pc inst
    vecs[0]  = mk(1,1,0,0,1, 0, 0,32'h00,0,0,0);
    vecs[1]  = mk(1,1,0,0,1, 1, 0,32'h00,0,0,0);
    vecs[2]  = mk(1,1,0,0,1, 1, 0,32'h00,0,0,0);
    vecs[3]  = mk(1,1,0,0,1, 1, 0,32'h00,0,0,0);
    vecs[4]  = mk(1,1,0,0,1, 1, 0,32'h00,0,0,0);
    vecs[5]  = mk(0,1,0,0,1, 1, 0,32'h00,0,0,0);
    vecs[6]  = mk(0,1,0,0,1, 1, 1,32'h00,0,0,0);
    vecs[7]  = mk(0,0,1,iw(32'h00),1, 1, 0,32'h04,0,0,0);
    vecs[8]  = mk(0,1,0,0,1, 1, 1,32'h04,1,32'h00,iw(32'h00));
    vecs[9]  = mk(0,0,1,iw(32'h04),1, 1, 0,32'h08,0,0,0);
    vecs[10] = mk(0,1,0,0,1, 1, 1,32'h08,1,32'h04,iw(32'h04));
    vecs[11] = mk(0,0,1,iw(32'h08),1, 1, 0,32'h0C,0,0,0);
    vecs[12] = mk(0,1,0,0,0, 1, 1,32'h0C,1,32'h08,iw(32'h08));
    vecs[13] = mk(0,0,1,iw(32'h0C),0, 1, 0,32'h10,1,32'h08,iw(32'h08));
    vecs[14] = mk(0,1,0,0,0, 1, 0,32'h10,1,32'h08,iw(32'h08));
    vecs[15] = mk(0,1,0,0,0, 1, 0,32'h10,1,32'h08,iw(32'h08));
    vecs[16] = mk(0,1,0,0,1, 1, 0,32'h10,1,32'h08,iw(32'h08));
    vecs[17] = mk(0,1,0,0,1, 1, 1,32'h10,1,32'h0C,iw(32'h0C));
    vecs[18] = mk(0,0,1,iw(32'h10),1, 1, 0,32'h14,0,0,0);
    vecs[19] = mk(0,0,0,0,1, 1, 1,32'h14,1,32'h10,iw(32'h10));
    vecs[20] = mk(0,0,0,0,1, 1, 1,32'h14,0,0,0);
    vecs[21] = mk(0,0,0,0,1, 1, 1,32'h14,0,0,0);
    vecs[22] = mk(0,0,0,0,1, 1, 1,32'h14,0,0,0);
    vecs[23] = mk(0,1,0,0,1, 1, 1,32'h14,0,0,0);
    vecs[24] = mk(0,0,0,0,1, 1, 0,32'h18,0,0,0);
    vecs[25] = mk(0,0,1,iw(32'h14),1, 1, 0,32'h18,0,0,0);
    vecs[26] = mk(0,0,0,0,1, 1, 1,32'h18,1,32'h14,iw(32'h14));

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst;
      bus.imem_ack    = vecs[i].ack;
      bus.imem_rvalid = vecs[i].rvalid;
      bus.imem_rdata  = vecs[i].rdata;
      bus.id_ready    = vecs[i].rdy;
      #1;
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_req", i),  {31'h0, bus.imem_req}, {31'h0, vecs[i].req});
        chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].addr);
        chk($sformatf("v%0d_vld", i),  {31'h0, bus.id_valid}, {31'h0, vecs[i].vld});
        chk($sformatf("v%0d_pc", i),   bus.id_pc, vecs[i].pc);
        chk($sformatf("v%0d_inst", i), bus.id_inst, vecs[i].inst);
      end
      @(posedge clk);
      #1;
    end
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b0; bus.id_ready = 1'b1;

    // Redirect while the 0x18 fetch is outstanding: its response must never reach ID.
    bus.imem_ack = 1'b1; #1;
    chk("a_req", {31'h0, bus.imem_req}, 32'h1);
    chk("a_addr", bus.imem_addr, 32'h18);
    cyc();
    bus.imem_ack = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("a_drop_req", {31'h0, bus.imem_req}, 32'h0);
    chk("a_drop_addr", bus.imem_addr, 32'h100);
    cyc();
    chk("a_drop_hold", {31'h0, bus.imem_req}, 32'h0);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    cyc();
    bus.imem_rvalid = 1'b0;
    chk("a_stale_vld", {31'h0, bus.id_valid}, 32'h0);
    chk("a_new_req", {31'h0, bus.imem_req}, 32'h1);
    chk("a_new_addr", bus.imem_addr, 32'h100);
    bus.imem_ack = 1'b1; cyc();
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA000_0100; cyc();
    bus.imem_rvalid = 1'b0;
    chk("a_id_vld", {31'h0, bus.id_valid}, 32'h1);
    chk("a_id_pc", bus.id_pc, 32'h100);
    chk("a_id_inst", bus.id_inst, 32'hA000_0100);
    cyc();

    // Redirect coincident with rvalid, unaligned target: no DROP, next fetch at 0x200.
    bus.imem_ack = 1'b1; cyc();
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0BAD_0104;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203;
    cyc();
    bus.imem_rvalid = 1'b0; bus.redirect_valid = 1'b0; bus.id_ready = 1'b0;
    chk("b_req", {31'h0, bus.imem_req}, 32'h1);
    chk("b_addr", bus.imem_addr, 32'h200);
    chk("b_vld", {31'h0, bus.id_valid}, 32'h0);
    bus.imem_ack = 1'b1; cyc();
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hC000_0200; cyc();
    bus.imem_rvalid = 1'b0;
    chk("b_id_pc", bus.id_pc, 32'h200);
    chk("b_id_inst", bus.id_inst, 32'hC000_0200);

    // Redirect with ack in REQ plus a pop: flush wins, pc not bumped, next rvalid dropped.
    bus.imem_ack = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300; bus.id_ready = 1'b1;
    cyc();
    bus.imem_ack = 1'b0; bus.redirect_valid = 1'b0;
    chk("c_req", {31'h0, bus.imem_req}, 32'h0);
    chk("c_addr", bus.imem_addr, 32'h300);
    chk("c_vld", {31'h0, bus.id_valid}, 32'h0);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0BAD_0204; cyc();
    bus.imem_rvalid = 1'b0;
    chk("c_drop_vld", {31'h0, bus.id_valid}, 32'h0);
    chk("c_req2", {31'h0, bus.imem_req}, 32'h1);
    chk("c_addr2", bus.imem_addr, 32'h300);
    bus.id_ready = 1'b0;
    bus.imem_ack = 1'b1; cyc();
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hC000_0300; cyc();
    bus.imem_rvalid = 1'b0;
    chk("c_id_pc", bus.id_pc, 32'h300);

    // Fill one entry, issue another fetch, then reset while it is in flight.
    bus.imem_ack = 1'b1; cyc();
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hD000_0304; cyc();
    bus.imem_rvalid = 1'b0; bus.id_ready = 1'b1; cyc();
    bus.id_ready = 1'b0;
    chk("d_head_pc", bus.id_pc, 32'h304);
    bus.imem_ack = 1'b1; cyc();
    bus.imem_ack = 1'b0;
    chk("d_wait_addr", bus.imem_addr, 32'h30C);
    rst = 1'b1; cyc();
    chk("d_rst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("d_rst_addr", bus.imem_addr, 32'h0);
    chk("d_rst_vld", {31'h0, bus.id_valid}, 32'h0);
    chk("d_rst_pc", bus.id_pc, 32'h0);
    chk("d_rst_inst", bus.id_inst, 32'h0);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0BAD_0308; cyc();
    bus.imem_rvalid = 1'b0;
    chk("d_late_vld", {31'h0, bus.id_valid}, 32'h0);
    rst = 1'b0; bus.id_ready = 1'b1;
    chk("d_idle_req", {31'h0, bus.imem_req}, 32'h0);
    cyc();
    chk("d_restart_req", {31'h0, bus.imem_req}, 32'h1);
    chk("d_restart_addr", bus.imem_addr, 32'h0);
    bus.imem_ack = 1'b1; cyc();
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_0000; cyc();
    bus.imem_rvalid = 1'b0;
    chk("d_id_vld", {31'h0, bus.id_valid}, 32'h1);
    chk("d_id_pc", bus.id_pc, 32'h0);
    chk("d_id_inst", bus.id_inst, 32'h1111_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the MeMIPS core. It sits directly downstream of the top-level clock/reset and upstream of the decode stage. It owns the PC and issues one word-aligned request at a time to instruction memory using a req/ack request channel and an rvalid response channel. It buffers returned instructions in a small FIFO that feeds ID through a valid/ready handshake, and it handles branch/jump redirects, including discarding a stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset (bits [1:0] must be 0)
BUF_DEPTH, 2, instruction buffer entries (legal 2..4)

Ports:
clk  in  1  core clock, all state on posedge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  memory accepts request this cycle (may be combinational on imem_req)
imem_rvalid  in  1  response valid; earliest the cycle after the accepting ack
imem_rdata  in  32  instruction word
redirect_valid  in  1  branch/jump/exception redirect from EX, single-cycle pulse
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
id_valid  out  1  buffer head valid to ID
id_pc  out  32  PC of head instruction
id_inst  out  32  head instruction
id_ready  in  1  ID consumes head when id_valid && id_ready

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, buffer empty. Outputs during and immediately after reset: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_pc=0, id_inst=0.
- States:
  - IDLE → REQ unconditionally on the first cycle with rst=0.
  - REQ: imem_req = (count < BUF_DEPTH); imem_addr = pc. On imem_req && imem_ack: req_pc <= pc, pc <= pc+4 (wraps mod 2^32), → WAIT. Address stays stable while req is held and not acked.
  - WAIT: imem_req=0. On imem_rvalid: push {req_pc, imem_rdata} into the buffer, → REQ.
  - DROP: imem_req=0. On imem_rvalid: discard the data, → REQ.
- At most one outstanding request. When REQ issues, count < BUF_DEPTH, so a push in WAIT always has room. A pop in the same cycle as a push is legal; count is unchanged.
- Pop: when id_valid && id_ready, the head advances on the next edge. id_pc and id_inst show the head entry and are 0 when the buffer is empty. Latency is rvalid at edge N → id_valid high after edge N; there is no bypass.
- Redirect has priority over all other events in the same cycle:
  - Always: pc <= {redirect_pc[31:2],2'b00}; buffer flushed (count=0, id_valid=0 next cycle). A simultaneous pop has no effect beyond the flush.
  - REQ without ack → REQ; the new address is presented next cycle.
  - REQ with imem_ack in the same cycle: the request counts as outstanding → DROP; pc is not incremented.
  - WAIT without rvalid → DROP.
  - WAIT with rvalid in the same cycle: data discarded, → REQ.
  - DROP without rvalid: stay in DROP with the new pc.
  - DROP with rvalid: → REQ.
  - IDLE: pc updated, → REQ.
- rst asserted mid-operation returns all state to reset values on the next edge, regardless of any outstanding request. A stale rvalid arriving after reset, while in IDLE, is ignored. The memory side is also reset by the same rst.
- imem_rvalid while in REQ or IDLE is a protocol violation: ignore it; flag it with an assertion in simulation.

Test Plan:
- Reset/start: rst high for 5 cycles, then low; memory acks combinationally with 1-cycle rvalid → imem_req first high in cycle 1 after release with addr 0x0. ID always ready → id_pc sequence 0x0, 0x4, 0x8, with one instruction every 2 cycles.
- Backpressure: id_ready=0 → exactly BUF_DEPTH=2 entries fill (pc 0x0, 0x4). imem_req is then low with imem_addr=0x8 held. Raise id_ready → head 0x0 pops and fetch of 0x8 resumes.
- Ack stall: hold imem_ack=0 for 4 cycles → imem_req=1 and imem_addr constant 0x0 throughout. The ack in cycle 5 moves the FSM to WAIT.
- Redirect in WAIT: fetch of 0x8 outstanding, redirect to 0x100 → FSM enters DROP. The 0x8 response is never seen by ID. The next imem_addr=0x100, and ID receives id_pc=0x100 next.
- Redirect coincident with rvalid, and redirect_pc=0x203: response discarded, no DROP state entered. The next request goes to 0x200.
- Redirect coincident with ack in REQ, plus reset mid-WAIT: the first case enters DROP and discards the following rvalid. Separately, asserting rst while in WAIT → outputs return to reset values, a late rvalid is ignored, and fetch restarts at RESET_PC.
